// File: rtl/mmio_regbank_if.sv
// mmio_regbank_if: CPU data-port bus between the CPU (master) and the MMIO
// register bank (slave). Address is a byte address; bit 12 selects MMIO vs dmem.
interface mmio_regbank_if #(
    parameter int DATA_W = 32
);
    logic [12:0]       address;
    logic [DATA_W-1:0] data_in;
    logic              wren;
    logic [DATA_W-1:0] data_out;

    modport master (output address, data_in, wren, input data_out);
    modport slave  (input address, data_in, wren, output data_out);
endinterface

// File: rtl/mmio_regbank.sv
// mmio_regbank: parametrised MMIO register bank for the game CPU data bus.
// NUM_CH channels x REGS_PER_CH config registers with per-register write
// strobes, registered read-back, sticky event flags with a maskable irq, and
// a dmem passthrough. Channel 31 is the global control channel
// (0 STATUS W1C, 1 MASK, 2 SNAP).
// Optional feature macro: MMIO_SNAPSHOT_EN enables the coherent ch_in shadow
// bank captured by a SNAP write.

// Per-channel config register file with one-cycle write strobes.
module mmio_regbank_ch #(
    parameter int REGS_PER_CH = 8,
    parameter int DATA_W      = 32
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_wr,
    input  logic [4:0]                             i_idx,
    input  logic [DATA_W-1:0]                      i_wdata,
    output logic [REGS_PER_CH-1:0][DATA_W-1:0]     o_cfg,
    output logic [REGS_PER_CH-1:0]                 o_strobe
);
    logic [REGS_PER_CH-1:0] w_hit;

    // One-hot register select for this channel's write.
    always_comb begin
        w_hit = '0;
        for (int r = 0; r < REGS_PER_CH; r++)
            w_hit[r] = i_wr && (i_idx == 5'(r));
    end

    // Config registers update on a hit; strobe is a registered copy of the hit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cfg    <= '0;
            o_strobe <= '0;
        end else begin
            o_strobe <= w_hit;
            for (int r = 0; r < REGS_PER_CH; r++)
                if (w_hit[r]) o_cfg[r] <= i_wdata;
        end
    end
endmodule

module mmio_regbank #(
    parameter int NUM_CH      = 8,
    parameter int REGS_PER_CH = 8,
    parameter int DATA_W      = 32
) (
    input  logic                                               i_clk,
    input  logic                                               i_rst_n,
    mmio_regbank_if.slave                                      bus,
    output logic [11:0]                                        o_dmem_address,
    output logic                                               o_dmem_wren,
    input  logic [DATA_W-1:0]                                  i_dmem_q,
    output logic [NUM_CH-1:0][REGS_PER_CH-1:0][DATA_W-1:0]     o_cfg,
    output logic [NUM_CH-1:0][REGS_PER_CH-1:0]                 o_wr_strobe,
    input  logic [NUM_CH-1:0][DATA_W-1:0]                      i_ch_in,
    input  logic [NUM_CH-1:0]                                  i_event,
    output logic                                               o_irq
);
    localparam logic [4:0] GLB_CH = 5'd31;

    logic              w_mmio;
    logic [4:0]        w_ch;
    logic [4:0]        w_idx;
    logic              w_idx_ok;
    logic              w_ch_wr;
    logic              w_glb_wr;
    logic [NUM_CH-1:0] w_w1c;
    logic [NUM_CH-1:0] w_rise;
    logic [DATA_W-1:0] w_rdata;
    logic [NUM_CH-1:0][DATA_W-1:0] w_ch_word;

    logic [NUM_CH-1:0] r_status;
    logic [NUM_CH-1:0] r_mask;
    logic [NUM_CH-1:0] r_ev_d;
    logic [NUM_CH-1:0] r_ev_prev;
    logic              r_irq;
    logic [DATA_W-1:0] r_rdata;
    logic              r_sel_mmio;

    assign w_mmio   = bus.address[12];
    assign w_ch     = bus.address[11:7];
    assign w_idx    = bus.address[6:2];
    assign w_idx_ok = 32'(w_idx) < 32'(REGS_PER_CH);
    // Channel 31 can never collide with a data channel since NUM_CH <= 31.
    assign w_ch_wr  = bus.wren && w_mmio && (32'(w_ch) < 32'(NUM_CH)) && w_idx_ok;
    assign w_glb_wr = bus.wren && w_mmio && (w_ch == GLB_CH);
    assign w_w1c    = (w_glb_wr && w_idx == 5'd0) ? bus.data_in[NUM_CH-1:0] : '0;
    assign w_rise   = r_ev_d & ~r_ev_prev;

    assign o_dmem_address = bus.address[11:0];
    assign o_dmem_wren    = bus.wren && !w_mmio;

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            mmio_regbank_ch #(
                .REGS_PER_CH (REGS_PER_CH),
                .DATA_W      (DATA_W)
            ) u_ch (
                .i_clk    (i_clk),
                .i_rst_n  (i_rst_n),
                .i_wr     (w_ch_wr && (w_ch == 5'(c))),
                .i_idx    (w_idx),
                .i_wdata  (bus.data_in),
                .o_cfg    (o_cfg[c]),
                .o_strobe (o_wr_strobe[c])
            );
        end
    endgenerate

`ifdef MMIO_SNAPSHOT_EN
    logic [NUM_CH-1:0][DATA_W-1:0] r_shadow;
    logic                          r_snap_vld;
    logic                          w_snap_wr;

    assign w_snap_wr = w_glb_wr && (w_idx == 5'd2) && bus.data_in[0];
    // Once a snapshot exists, idx-0 reads come from the shadow for coherence.
    assign w_ch_word = r_snap_vld ? r_shadow : i_ch_in;

    // Shadow bank captures every channel's live word on a SNAP write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow   <= '0;
            r_snap_vld <= 1'b0;
        end else if (w_snap_wr) begin
            r_shadow   <= i_ch_in;
            r_snap_vld <= 1'b1;
        end
    end
`else
    logic r_snap_vld;
    assign r_snap_vld = 1'b0;
    assign w_ch_word  = i_ch_in;
`endif

    // Read mux: global regs, in-range channel regs, else 0.
    always_comb begin
        w_rdata = '0;
        if (w_mmio) begin
            if (w_ch == GLB_CH) begin
                case (w_idx)
                    5'd0:    w_rdata = DATA_W'(r_status);
                    5'd1:    w_rdata = DATA_W'(r_mask);
                    5'd2:    w_rdata = DATA_W'({r_snap_vld, 1'b0});
                    default: w_rdata = '0;
                endcase
            end else begin
                for (int ch = 0; ch < NUM_CH; ch++)
                    for (int r = 0; r < REGS_PER_CH; r++)
                        if (w_ch == 5'(ch) && w_idx == 5'(r))
                            w_rdata = (r == 0) ? w_ch_word[ch] : o_cfg[ch][r];
            end
        end
    end

    // Registered read data; the MMIO/dmem select is registered to line up with
    // dmem's one-cycle read latency. Select resets to MMIO so data_out is 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata    <= '0;
            r_sel_mmio <= 1'b1;
        end else begin
            r_rdata    <= w_rdata;
            r_sel_mmio <= w_mmio;
        end
    end

    assign bus.data_out = r_sel_mmio ? r_rdata : i_dmem_q;

    // Event edge detect, sticky STATUS (set beats W1C), MASK and irq.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ev_d    <= '0;
            r_ev_prev <= '0;
            r_status  <= '0;
            r_mask    <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_ev_d    <= i_event;
            r_ev_prev <= r_ev_d;
            r_status  <= (r_status & ~w_w1c) | w_rise;
            if (w_glb_wr && w_idx == 5'd1) r_mask <= bus.data_in[NUM_CH-1:0];
            r_irq     <= |(r_status & r_mask);
        end
    end

    assign o_irq = r_irq;
endmodule

// File: tb/tb_mmio_regbank.sv
// tb_mmio_regbank: table-driven bus vectors plus hand sequences for events,
// snapshot and asynchronous reset. NUM_CH=8, REGS_PER_CH=8, DATA_W=32.
module tb_mmio_regbank;
    localparam int NC = 8;
    localparam int NR = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [11:0]       dmem_address;
    logic              dmem_wren;
    logic [31:0]       dmem_q = '0;
    logic [NC*NR*32-1:0] cfg;
    logic [NC*NR-1:0]  strobe;
    logic [NC*32-1:0]  ch_in;
    logic [NC-1:0]     ev = '0;
    logic              irq;
    logic [31:0]       dmem [0:1023];

    int checks = 0;
    int failures = 0;

    mmio_regbank_if #(.DATA_W(32)) bus();

    mmio_regbank #(.NUM_CH(NC), .REGS_PER_CH(NR), .DATA_W(32)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .bus            (bus),
        .o_dmem_address (dmem_address),
        .o_dmem_wren    (dmem_wren),
        .i_dmem_q       (dmem_q),
        .o_cfg          (cfg),
        .o_wr_strobe    (strobe),
        .i_ch_in        (ch_in),
        .i_event        (ev),
        .o_irq          (irq)
    );

    always #5 clk = ~clk;

    // Simple synchronous dmem with one-cycle read latency.
    always @(posedge clk) begin
        if (dmem_wren) dmem[dmem_address[11:2]] <= bus.data_in;
        dmem_q <= dmem[dmem_address[11:2]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cfg_word(input int w);
        return cfg[w*32 +: 32];
    endfunction

    function automatic logic [63:0] exp_strobe(input logic [12:0] a, input logic we);
        logic [63:0] s;
        s = '0;
        if (we && a[12] && a[11:7] < 5'd8 && a[6:2] < 5'd8)
            s[{a[9:7], a[4:2]}] = 1'b1;
        return s;
    endfunction

    typedef struct {
        string       name;
        logic [12:0] addr;
        logic [31:0] wdata;
        logic        wren;
        logic        chk;
        logic [31:0] exp;
        logic        dwren;
    } vec_t;

    vec_t vecs[$];

    initial begin
        for (int i = 0; i < 1024; i++) dmem[i] = '0;
        for (int c = 0; c < NC; c++) ch_in[c*32 +: 32] = 32'hC0DE_0000 + 32'(c);
        bus.address = '0;
        bus.data_in = '0;
        bus.wren    = 1'b0;

        vecs.push_back('{"wr_ch0_idx0",   13'h1000, 32'h0000_0010, 1'b1, 1'b1, 32'hC0DE_0000, 1'b0});
        vecs.push_back('{"wr_ch0_idx3",   13'h100C, 32'h0160_00FA, 1'b1, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{"rd_ch0_idx3",   13'h100C, 32'h0,         1'b0, 1'b1, 32'h0160_00FA, 1'b0});
        vecs.push_back('{"rd_ch0_idx0",   13'h1000, 32'h0,         1'b0, 1'b1, 32'hC0DE_0000, 1'b0});
        vecs.push_back('{"wr_ch9",        13'h1488, 32'h1234_5678, 1'b1, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{"rd_ch9",        13'h1488, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{"wr_idx10",      13'h1028, 32'h0000_AAAA, 1'b1, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{"rd_idx10",      13'h1028, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{"wr_ch3_idx1",   13'h1184, 32'hCAFE_F00D, 1'b1, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{"rd_ch3_idx1",   13'h1184, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D, 1'b0});
        vecs.push_back('{"rd_ch3_idx0",   13'h1180, 32'h0,         1'b0, 1'b1, 32'hC0DE_0003, 1'b0});
        vecs.push_back('{"wr_mask",       13'h1F84, 32'h0000_0004, 1'b1, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{"rd_mask",       13'h1F84, 32'h0,         1'b0, 1'b1, 32'h0000_0004, 1'b0});
        vecs.push_back('{"wr_glb_idx3",   13'h1F8C, 32'h0000_FFFF, 1'b1, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{"rd_glb_idx3",   13'h1F8C, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{"wr_dmem",       13'h0040, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         1'b1});
        vecs.push_back('{"rd_dmem",       13'h0040, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{"wr_mmio_alias", 13'h1040, 32'h1111_1111, 1'b1, 1'b1, 32'h0,         1'b0});
        vecs.push_back('{"rd_dmem_again", 13'h0040, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0});

        // Reset state.
        #12;
        check("reset_data_out", bus.data_out, 32'h0);
        check("reset_strobe", strobe, 64'h0);
        check("reset_irq", irq, 1'b0);
        check("reset_cfg_or", |cfg, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors.
        foreach (vecs[i]) begin
            @(negedge clk);
            bus.address = vecs[i].addr;
            bus.data_in = vecs[i].wdata;
            bus.wren    = vecs[i].wren;
            #1;
            check({vecs[i].name, "_dwren"}, dmem_wren, vecs[i].dwren);
            cyc();
            check({vecs[i].name, "_strobe"}, strobe, exp_strobe(vecs[i].addr, vecs[i].wren));
            if (vecs[i].chk) check({vecs[i].name, "_rd"}, bus.data_out, vecs[i].exp);
        end
        check("cfg_w0", cfg_word(0), 32'h0000_0010);
        check("cfg_w3", cfg_word(3), 32'h0160_00FA);
        check("cfg_w25", cfg_word(25), 32'hCAFE_F00D);

        // Event and interrupt (MASK=0x4 already set).
        @(negedge clk);
        bus.address = 13'h1F80; bus.wren = 1'b0; bus.data_in = '0;
        ev = 8'h04;
        cyc();
        check("ev_irq_n", irq, 1'b0);
        @(negedge clk); ev = '0;
        cyc();
        check("ev_irq_n1", irq, 1'b0);
        @(negedge clk);
        cyc();
        check("ev_irq_n2", irq, 1'b1);
        check("ev_status", bus.data_out, 32'h4);

        // W1C coinciding with a new rising edge: set wins.
        @(negedge clk); ev = 8'h04;
        cyc();
        @(negedge clk); ev = '0; bus.wren = 1'b1; bus.data_in = 32'h4;
        cyc();
        @(negedge clk); bus.wren = 1'b0;
        cyc();
        check("w1c_race_status", bus.data_out, 32'h4);
        check("w1c_race_irq", irq, 1'b1);

        // Plain W1C clears, irq follows a cycle later.
        @(negedge clk); bus.wren = 1'b1; bus.data_in = 32'h4;
        cyc();
        check("w1c_irq_k", irq, 1'b1);
        @(negedge clk); bus.wren = 1'b0;
        cyc();
        check("w1c_irq_k1", irq, 1'b0);
        check("w1c_status", bus.data_out, 32'h0);

        // Snapshot.
        @(negedge clk);
        ch_in[31:0] = 32'h0010_0020;
        bus.address = 13'h1F88; bus.data_in = 32'h1; bus.wren = 1'b1;
        cyc();
        @(negedge clk);
        ch_in[31:0] = 32'h0030_0040;
        bus.wren = 1'b0;
        cyc();
`ifdef MMIO_SNAPSHOT_EN
        check("snap_rd", bus.data_out, 32'h2);
`else
        check("snap_rd", bus.data_out, 32'h0);
`endif
        @(negedge clk); bus.address = 13'h1000;
        cyc();
`ifdef MMIO_SNAPSHOT_EN
        check("snap_ch0", bus.data_out, 32'h0010_0020);
`else
        check("snap_ch0", bus.data_out, 32'h0030_0040);
`endif

        // Async reset mid-operation.
        @(negedge clk); bus.address = 13'h100C;
        cyc();
        check("pre_rst_rd", bus.data_out, 32'h0160_00FA);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cfg_w3", cfg_word(3), 32'h0);
        check("arst_data_out", bus.data_out, 32'h0);
        check("arst_irq", irq, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.address = 13'h1010; bus.data_in = 32'h55; bus.wren = 1'b1;
        cyc();
        check("post_rst_cfg_w4", cfg_word(4), 32'h55);
        check("post_rst_strobe", strobe, 64'h10);
        @(negedge clk); bus.wren = 1'b0;
        cyc();
        check("post_rst_strobe_drop", strobe, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
